// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: operand-select codes, register-index width and
// the shadow-stage record used by the forwarding/select logic.
package cpu_pkg;

   localparam int unsigned REG_AW   = 5;
   localparam int unsigned N_SHADOW = 4;

   // Shadow pipeline slot indices, youngest first.
   localparam int unsigned STG_EX  = 0;
   localparam int unsigned STG_MEM = 1;
   localparam int unsigned STG_WB  = 2;
   localparam int unsigned STG_RET = 3;

   // Operand-mux select encoding; values are fixed by the EX-stage mux wiring.
   typedef enum logic [1:0] {
      SEL_REG   = 2'b00,
      SEL_EXMEM = 2'b01,
      SEL_MEMWB = 2'b10,
      SEL_RET   = 2'b11
   } sel_e;

   typedef struct packed {
      logic              we;
      logic              is_load;
      logic [REG_AW-1:0] dst;
   } stage_t;

   localparam stage_t STAGE_BUBBLE = '{we: 1'b0, is_load: 1'b0, dst: '0};

   function automatic logic stage_hits(input stage_t st, input logic [REG_AW-1:0] src);
      return st.we && (st.dst == src);
   endfunction

endpackage

// File: rtl/fwd_cmp.sv
// Per-operand priority comparator: picks the youngest in-flight producer of
// i_src and returns the operand-mux select code it will need next cycle.
module fwd_cmp
   import cpu_pkg::*;
#(
   parameter logic [REG_AW-1:0] ZERO_REG = '0
) (
   input  logic [REG_AW-1:0] i_src,
   input  stage_t            i_ex,
   input  stage_t            i_mem,
   input  stage_t            i_wb,
   output logic [1:0]        o_sel
);

   // The producer one stage ahead now is one stage further along when the
   // consumer reaches EX, hence EX->EX/MEM, MEM->MEM/WB, WB->post-WB.
   always_comb begin
      o_sel = SEL_REG;
      if (i_src != ZERO_REG) begin
         if (stage_hits(i_ex, i_src)) begin
            o_sel = SEL_EXMEM;
         end else if (stage_hits(i_mem, i_src)) begin
            o_sel = SEL_MEMWB;
         end else if (stage_hits(i_wb, i_src)) begin
            o_sel = SEL_RET;
         end
      end
   end

endmodule

// File: rtl/fwd_sel_unit.sv
// Operand-select producer for the EX-stage operand muxes with load-use stall.
// Optional build macro FWD_STATS_EN adds stall_cnt / fwd_cnt statistics ports.
module fwd_sel_unit
   import cpu_pkg::*;
#(
   parameter int unsigned       REG_AW   = cpu_pkg::REG_AW,
   parameter logic [REG_AW-1:0] ZERO_REG = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic [REG_AW-1:0] id_dst,
   input  logic              flush,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              stall
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       fwd_cnt
`endif
);

   stage_t     r_pipe [N_SHADOW];
   stage_t     w_id_entry;
   stage_t     w_ex_adv;
   logic [1:0] w_cmp_a;
   logic [1:0] w_cmp_b;
   logic [1:0] w_sel_a_nxt;
   logic [1:0] w_sel_b_nxt;
   logic [1:0] r_sel_a;
   logic [1:0] r_sel_b;
   logic       w_stall;
   logic       w_ex_match;
   logic       w_issue;

   assign w_ex_match = (r_pipe[STG_EX].dst == id_rs) || (r_pipe[STG_EX].dst == id_rt);

   assign w_stall = id_valid
                 && r_pipe[STG_EX].is_load
                 && r_pipe[STG_EX].we
                 && (r_pipe[STG_EX].dst != ZERO_REG)
                 && w_ex_match;

   assign w_issue = id_valid && !w_stall && !flush;

   always_comb begin
      w_id_entry = STAGE_BUBBLE;
      if (w_issue) begin
         w_id_entry.we      = id_we;
         w_id_entry.is_load = id_is_load;
         w_id_entry.dst     = id_dst;
      end
   end

   // A taken branch squashes the instruction already in EX as well as ID.
   assign w_ex_adv = flush ? STAGE_BUBBLE : r_pipe[STG_EX];

   fwd_cmp #(
      .ZERO_REG (ZERO_REG)
   ) u_cmp_a (
      .i_src (id_rs),
      .i_ex  (r_pipe[STG_EX]),
      .i_mem (r_pipe[STG_MEM]),
      .i_wb  (r_pipe[STG_WB]),
      .o_sel (w_cmp_a)
   );

   fwd_cmp #(
      .ZERO_REG (ZERO_REG)
   ) u_cmp_b (
      .i_src (id_rt),
      .i_ex  (r_pipe[STG_EX]),
      .i_mem (r_pipe[STG_MEM]),
      .i_wb  (r_pipe[STG_WB]),
      .o_sel (w_cmp_b)
   );

   assign w_sel_a_nxt = w_issue ? w_cmp_a : SEL_REG;
   assign w_sel_b_nxt = w_issue ? w_cmp_b : SEL_REG;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_SHADOW; i++) begin
            r_pipe[i] <= STAGE_BUBBLE;
         end
         r_sel_a <= SEL_REG;
         r_sel_b <= SEL_REG;
      end else begin
         r_pipe[STG_EX]  <= w_id_entry;
         r_pipe[STG_MEM] <= w_ex_adv;
         r_pipe[STG_WB]  <= r_pipe[STG_MEM];
         r_pipe[STG_RET] <= r_pipe[STG_WB];
         r_sel_a         <= w_sel_a_nxt;
         r_sel_b         <= w_sel_b_nxt;
      end
   end

   assign sel_a = r_sel_a;
   assign sel_b = r_sel_b;
   assign stall = w_stall;

`ifdef FWD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;
   logic [31:0] w_fwd_inc;

   assign w_fwd_inc = 32'(w_sel_a_nxt != SEL_REG) + 32'(w_sel_b_nxt != SEL_REG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'(w_stall);
         r_fwd_cnt   <= r_fwd_cnt + w_fwd_inc;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_fwd_sel_unit.sv
// Directed-vector bench for fwd_sel_unit: per-cycle table of ID inputs with
// expected pre-edge stall and post-edge selects, plus reset corner sequences.
module tb_fwd_sel_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       id_we;
   logic       id_is_load;
   logic [4:0] id_dst;
   logic       flush;
   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic       stall;
`ifdef FWD_STATS_EN
   logic [31:0] stall_cnt;
   logic [31:0] fwd_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fwd_sel_unit #(
      .REG_AW   (5),
      .ZERO_REG (5'd0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .id_dst     (id_dst),
      .flush      (flush),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .stall      (stall)
`ifdef FWD_STATS_EN
      ,
      .stall_cnt  (stall_cnt),
      .fwd_cnt    (fwd_cnt)
`endif
   );

   typedef struct {
      bit       valid;
      bit [4:0] rs;
      bit [4:0] rt;
      bit       we;
      bit       ld;
      bit [4:0] dst;
      bit       fl;
      bit       exp_stall;
      bit [1:0] exp_a;
      bit [1:0] exp_b;
   } vec_t;

   localparam int NV = 28;
   vec_t tbl [NV];

   function automatic vec_t mk(input bit v, input int rs, input int rt, input bit we,
                               input bit ld, input int dst, input bit fl,
                               input bit st, input int ea, input int eb);
      vec_t r;
      r.valid = v;  r.rs = 5'(rs); r.rt = 5'(rt); r.we = we; r.ld = ld;
      r.dst = 5'(dst); r.fl = fl; r.exp_stall = st; r.exp_a = 2'(ea); r.exp_b = 2'(eb);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input int rs, input int rt, input bit we,
                        input bit ld, input int dst, input bit fl);
      id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_we = we;
      id_is_load = ld; id_dst = 5'(dst); flush = fl;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_stalls;
      int exp_fwds;

      // ALU dependency chain on r3
      tbl[0]  = mk(1, 0, 0, 1, 0, 3, 0,  0, 0, 0);
      tbl[1]  = mk(1, 3, 0, 0, 0, 0, 0,  0, 1, 0);
      tbl[2]  = mk(1, 0, 3, 0, 0, 0, 0,  0, 0, 2);
      tbl[3]  = mk(1, 3, 0, 0, 0, 0, 0,  0, 3, 0);
      tbl[4]  = mk(1, 3, 3, 0, 0, 0, 0,  0, 0, 0);
      // load-use on r5, consumer held through the stall
      tbl[5]  = mk(1, 0, 0, 1, 1, 5, 0,  0, 0, 0);
      tbl[6]  = mk(1, 0, 5, 0, 0, 0, 0,  1, 0, 0);
      tbl[7]  = mk(1, 0, 5, 0, 0, 0, 0,  0, 0, 2);
      // r7 written three times: youngest wins, then older ones
      tbl[8]  = mk(1, 0, 0, 1, 0, 7, 0,  0, 0, 0);
      tbl[9]  = mk(1, 0, 0, 1, 0, 7, 0,  0, 0, 0);
      tbl[10] = mk(1, 0, 0, 1, 0, 7, 0,  0, 0, 0);
      tbl[11] = mk(1, 7, 7, 0, 0, 0, 0,  0, 1, 1);
      tbl[12] = mk(1, 7, 0, 0, 0, 0, 0,  0, 2, 0);
      tbl[13] = mk(1, 0, 7, 0, 0, 0, 0,  0, 0, 3);
      // r0 writes and a load to r0 never forward or stall
      tbl[14] = mk(1, 0, 0, 1, 0, 0, 0,  0, 0, 0);
      tbl[15] = mk(1, 0, 0, 1, 1, 0, 0,  0, 0, 0);
      tbl[16] = mk(1, 0, 0, 0, 0, 0, 0,  0, 0, 0);
      // flush with dependent in ID squashes r9 writer in EX too
      tbl[17] = mk(1, 0, 0, 1, 0, 9, 0,  0, 0, 0);
      tbl[18] = mk(1, 9, 0, 0, 0, 0, 1,  0, 0, 0);
      tbl[19] = mk(1, 9, 9, 0, 0, 0, 0,  0, 0, 0);
      // invalid ID slots
      tbl[20] = mk(0, 0, 0, 1, 0, 4, 0,  0, 0, 0);
      tbl[21] = mk(1, 4, 4, 0, 0, 0, 0,  0, 0, 0);
      tbl[22] = mk(1, 0, 0, 1, 0, 6, 0,  0, 0, 0);
      tbl[23] = mk(0, 6, 0, 0, 0, 0, 0,  0, 0, 0);
      tbl[24] = mk(1, 6, 6, 0, 0, 0, 0,  0, 2, 2);
      // flush coinciding with load-use stall
      tbl[25] = mk(1, 0, 0, 1, 1, 2, 0,  0, 0, 0);
      tbl[26] = mk(1, 2, 0, 0, 0, 0, 1,  1, 0, 0);
      tbl[27] = mk(1, 2, 0, 0, 0, 0, 0,  0, 0, 0);

      // Reset held with random inputs
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'($urandom), int'($urandom_range(31)), int'($urandom_range(31)),
               1'($urandom), 1'($urandom), int'($urandom_range(31)), 1'($urandom));
         @(posedge clk); #1;
         check($sformatf("rst%0d_sel_a", i), 32'(sel_a), 32'd0);
         check($sformatf("rst%0d_sel_b", i), 32'(sel_b), 32'd0);
         check($sformatf("rst%0d_stall", i), 32'(stall), 32'd0);
      end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_sel_a", 32'(sel_a), 32'd0);
      check("post_rst_sel_b", 32'(sel_b), 32'd0);
`ifdef FWD_STATS_EN
      check("post_rst_stall_cnt", stall_cnt, 32'd0);
      check("post_rst_fwd_cnt", fwd_cnt, 32'd0);
`endif

      exp_stalls = 0;
      exp_fwds   = 0;
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(tbl[i].valid, int'(tbl[i].rs), int'(tbl[i].rt), tbl[i].we,
               tbl[i].ld, int'(tbl[i].dst), tbl[i].fl);
         #1;
         check($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
         @(posedge clk); #1;
         check($sformatf("v%0d_sel_a", i), 32'(sel_a), 32'(tbl[i].exp_a));
         check($sformatf("v%0d_sel_b", i), 32'(sel_b), 32'(tbl[i].exp_b));
         exp_stalls += int'(tbl[i].exp_stall);
         exp_fwds   += int'(tbl[i].exp_a != 2'd0) + int'(tbl[i].exp_b != 2'd0);
      end
`ifdef FWD_STATS_EN
      check("stats_stall_cnt", stall_cnt, 32'(exp_stalls));
      check("stats_fwd_cnt", fwd_cnt, 32'(exp_fwds));
`endif

      // Asynchronous reset mid-operation: r8 forward pending and load-use live
      @(negedge clk);
      drive(1, 0, 0, 1, 0, 8, 0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 8, 0, 1, 1, 10, 0);
      @(posedge clk); #1;
      check("mid_sel_a_before", 32'(sel_a), 32'd1);
      @(negedge clk);
      drive(1, 10, 8, 0, 0, 0, 0);
      #1;
      check("mid_stall_before", 32'(stall), 32'd1);
      rst = 1'b1;
      #1;
      check("async_sel_a", 32'(sel_a), 32'd0);
      check("async_stall", 32'(stall), 32'd0);
`ifdef FWD_STATS_EN
      check("async_stall_cnt", stall_cnt, 32'd0);
      check("async_fwd_cnt", fwd_cnt, 32'd0);
`endif
      #1;
      rst = 1'b0;
      #1;
      check("after_rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      check("after_rst_sel_a", 32'(sel_a), 32'd0);
      check("after_rst_sel_b", 32'(sel_b), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fwd_sel_unit.md
Name: fwd_sel_unit

Overview:
- Producer side of the 2-bit operand-select interface that drives the 32-bit 4:1 operand multiplexers in the EX stage of the 5-stage pipeline.
- Keeps a shadow pipeline of destination-register and write/load flags for EX, MEM, WB and one post-WB stage.
- Compares ID-stage source registers against that pipeline, then registers the EX-stage select codes for operands A and B.
- Raises a one-cycle load-use stall request.

Parameters:
- REG_AW, 5, register-index width.
- ZERO_REG, 0, register index that never forwards (reads as hardwired zero).

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  REG_AW  ID source register for operand A.
- id_rt  input  REG_AW  ID source register for operand B.
- id_we  input  1  ID instruction writes a register.
- id_is_load  input  1  ID instruction is a load.
- id_dst  input  REG_AW  ID destination register.
- flush  input  1  squash ID and EX (branch taken).
- sel_a  output  2  EX operand-A select.
- sel_b  output  2  EX operand-B select.
- stall  output  1  hold PC and IF/ID; bubble into EX.

Behaviour:
- Select encoding (shared with the mux):
  - 00 register file.
  - 01 EX/MEM ALU result.
  - 10 MEM/WB result.
  - 11 post-WB retired value (covers the regfile write/read same-cycle gap).
- Shadow stages EX, MEM, WB, RET each hold {we, is_load, dst}. All advance every clock.
  - ID→EX entry is a bubble (we=0, is_load=0) when stall, flush or !id_valid is true. Otherwise it is the ID fields.
  - flush also clears the EX entry before it advances into MEM.
- stall is combinational:
  - stall = id_valid & EX.is_load & EX.we & EX.dst != ZERO_REG & (EX.dst == id_rs | EX.dst == id_rt).
  - Lasts exactly one cycle per hazard, because the bubble removes the match.
- Select decision for each source s:
  - If s == ZERO_REG → 00.
  - Else priority: newest producer wins. Checks run in this order:
    - ID→EX-entering slot's successor, i.e. current EX (we, dst==s) → 01.
    - MEM → 10.
    - WB → 11.
    - Otherwise → 00.
- The decision is computed in ID and registered into sel_a/sel_b at the clock edge, so there is 1-cycle latency.
- sel registers load 00 when stall, flush or !id_valid.
- Simultaneous matches in several stages: the youngest stage wins.
- Reset:
  - All shadow-stage entries clear to we=0, is_load=0, dst=0.
  - sel_a=sel_b=00.
  - stall=0 follows from the cleared state.
- Reset asserted mid-operation clears the state immediately, independent of clk. The first edge after deassertion behaves as from the empty pipeline.
- If flush and stall coincide, flush dominates: a bubble enters EX, and stall is still reported for that cycle (harmless).

Optional Feature:
- Macro FWD_STATS_EN.
- When defined, adds two output ports:
  - stall_cnt (32) counts cycles with stall=1.
  - fwd_cnt (32) counts edges where a non-00 code is loaded into sel_a or sel_b (both counted when both are non-00).
  - Both counters clear on rst and wrap modulo 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - The SEL_REG/SEL_EXMEM/SEL_MEMWB/SEL_RET 2-bit constants.
  - REG_AW.
  - A stage-record typedef {we, is_load, dst}.
- One natural sub-module, fwd_cmp: combinational per-operand priority comparator taking source index plus three stage records and returning the 2-bit code. Instantiate it twice.

Test Plan:
- Reset: hold rst with random inputs → sel_a=sel_b=00, stall=0.
  - Deassert with id_rs=id_rt=0 → stays 00.
- Back-to-back ALU dependency: issue "r3←" (id_we=1, id_dst=3), then next instruction id_rs=3 → after the edge sel_a=01.
  - Third instruction id_rt=3 → sel_b=10.
  - Fourth instruction id_rs=3 → sel_a=11.
  - Fifth instruction → 00.
- Load-use: load r5, then id_rt=5 → stall=1 for exactly one cycle and sel_b=00 that edge.
  - Next edge → sel_b=10.
- Priority: write r7 three times consecutively, then read r7 → sel_a=01 (youngest wins).
- Zero register: write r0, then read r0 → sel=00 and no stall, including for a load to r0.
- Flush: write r9, assert flush together with the dependent instruction → EX bubble, sel_a=00.
  - Reset pulse mid-sequence → all state cleared immediately.
  - With FWD_STATS_EN, check stall_cnt=1 after the load-use case.
